handshake_sink_const_check: RTL and testbench
=============================================

Name: handshake_sink_const_check

Overview:
- Terminal consumer for one elastic data channel. It is the receiving end of a constant-source channel.
- Accepts tokens under valid/ready, compares each accepted token against a compile-time expected constant, and keeps token and mismatch statistics.
- Can inject periodic backpressure to exercise the upstream producer's stall path.
- Sits at the outs end of a constant generator, or of any dataflow edge under test, in self-checking blocks.

Parameters:
- DATA_WIDTH, 32, width of the ins data bus.
- EXPECTED, 12'b110011100111, expected token value; zero-extended or truncated to DATA_WIDTH.
- CNT_WIDTH, 16, width of the token and error counters.
- STALL_PERIOD, 0, backpressure period in cycles. 0 means never stall; N>=2 means ins_ready is low 1 cycle in every N; 1 is illegal.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- ins  input  DATA_WIDTH  channel data
- ins_valid  input  1  channel valid
- ins_ready  output  1  channel ready
- clear  input  1  synchronous clear of statistics
- tok_count  output  CNT_WIDTH  accepted tokens since reset/clear
- err_count  output  CNT_WIDTH  mismatching tokens since reset/clear
- err_sticky  output  1  at least one mismatch since reset/clear
- first_err_data  output  DATA_WIDTH  data of the first mismatching token
- proto_err  output  1  sticky protocol violation flag (see Optional Feature)

Behaviour:
- Reset (rst low, asynchronous) clears all registers. During reset: ins_ready=0, tok_count=0, err_count=0, err_sticky=0, first_err_data=0, proto_err=0, stall counter=0.
- Transfer condition: xfer = ins_valid & ins_ready. Tokens are consumed with zero latency. ins_ready never depends on ins_valid.
- Ready generation:
  - Registered enable ready_en is 0 in reset and 1 from the first clock edge after rst deasserts.
  - STALL_PERIOD=0: ins_ready = ready_en.
  - STALL_PERIOD=N: stall_cnt counts 0..N-1 every cycle and wraps to 0. ins_ready = ready_en & (stall_cnt != N-1).
  - The stall counter runs regardless of ins_valid and is unaffected by clear.
- On xfer, with clear=0:
  - tok_count increments, saturating at all-ones.
  - If ins != EXPECTED: err_count increments (saturating) and err_sticky is set.
  - If err_sticky was 0 before this edge, first_err_data captures ins.
- clear=1 with no xfer: tok_count, err_count, err_sticky and first_err_data go to 0 on the next edge.
- clear=1 with xfer in the same cycle: statistics restart with that token.
  - tok_count=1.
  - On mismatch: err_count=1, err_sticky=1, first_err_data=ins.
  - On match: err_count=0, err_sticky=0, first_err_data=0.
- Saturated counters hold all-ones until clear or reset. No wrap-around.
- All statistics outputs are registered and reflect transfers up to the previous edge (1-cycle visibility latency).
- Reset mid-token: a token presented while rst is low is not accepted and not counted.

Optional Feature:
- Macro: HANDSHAKE_SINK_PROTO_CHECK_EN.
- Enabled: a pending flag is set when ins_valid & ~ins_ready, and data_hold registers ins on that cycle.
  - On the next cycle with pending=1, proto_err is set if ins_valid=0 (valid withdrawn) or ins != data_hold (data changed while stalled).
  - proto_err is sticky and cleared by clear or reset.
- Disabled: no pending/data_hold logic; proto_err is tied 0.

Decomposition:
- Shared package handshake_check_pkg holds:
  - default EXPECTED constant (12'b110011100111);
  - default CNT_WIDTH;
  - saturating-increment function;
  - STALL_PERIOD legality check.
- Sub-module handshake_stall_gen (STALL_PERIOD, clk, rst -> ready_mask) holds the ready_en register and stall counter. It is reusable by other sinks and buffers.

Test Plan:
- Reset release, STALL_PERIOD=0, EXPECTED=0xCE7, ins=0xCE7 with ins_valid held high for 10 cycles:
  - ins_ready=0 during reset, 1 from the first edge after release;
  - tok_count=10, err_count=0, err_sticky=0.
- Tokens 0xCE7, 0x001, 0xCE7, 0x0FF:
  - tok_count=4, err_count=2, err_sticky=1, first_err_data=0x001.
- STALL_PERIOD=4, ins_valid held high for 16 cycles:
  - ins_ready low exactly on cycles 3, 7, 11, 15 after release;
  - tok_count=12.
- clear asserted together with a transfer of 0x123, after prior errors:
  - next edge: tok_count=1, err_count=1, first_err_data=0x123.
- CNT_WIDTH=4, 20 mismatching tokens:
  - tok_count=15, err_count=15, both holding at 15.
- Macro defined, STALL_PERIOD=4:
  - valid dropped during the stall cycle -> proto_err=1 on the next edge;
  - data changed during a stall -> proto_err=1;
  - clear -> proto_err=0.
  - Macro undefined, same stimulus -> proto_err stays 0.

Source files
------------

// File: rtl/handshake_check_pkg.sv
// Shared definitions for handshake checkers: default constants, saturating increment
// and stall-period legality.
package handshake_check_pkg;

  localparam int unsigned DEFAULT_CNT_WIDTH = 16;
  localparam logic [11:0] DEFAULT_EXPECTED  = 12'b110011100111;

  // Counters up to 64 bits wide hold at all-ones instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] top;
    top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value == top) ? value : value + 64'd1;
  endfunction

  function automatic bit stall_period_legal(input int unsigned period);
    return (period == 0) || (period >= 2);
  endfunction

endpackage

// File: rtl/handshake_stall_gen.sv
// Ready mask generator: one-cycle ready enable after reset plus optional periodic
// stall (low one cycle in every STALL_PERIOD).
module handshake_stall_gen
  import handshake_check_pkg::*;
#(
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic clk,
  input  logic rst,
  output logic ready_mask
);

  logic ready_en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en_q <= 1'b0;
    else      ready_en_q <= 1'b1;
  end

  if (!stall_period_legal(STALL_PERIOD)) begin : g_illegal
    $error("handshake_stall_gen: STALL_PERIOD of 1 would never assert ready");
  end

  if (STALL_PERIOD == 0) begin : g_nostall
    assign ready_mask = ready_en_q;
  end else begin : g_stall
    localparam int unsigned CW = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(STALL_PERIOD - 1);

    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    // Free-running: ignores valid and clear so the stall phase is predictable.
    always_comb begin
      stall_cnt_d = (stall_cnt_q == LAST) ? '0 : stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
    end

    assign ready_mask = ready_en_q & (stall_cnt_q != LAST);
  end

endmodule

// File: rtl/handshake_sink_const_check.sv
// Terminal sink that checks every accepted token against EXPECTED and keeps statistics.
// Optional protocol checker enabled by macro HANDSHAKE_SINK_PROTO_CHECK_EN.
module handshake_sink_const_check
  import handshake_check_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED     = DATA_WIDTH'(DEFAULT_EXPECTED),
  parameter int unsigned           CNT_WIDTH    = DEFAULT_CNT_WIDTH,
  parameter int unsigned           STALL_PERIOD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  tok_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_sticky,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  proto_err
);

  logic xfer, mismatch;
  logic [CNT_WIDTH-1:0]  tok_q, tok_d, err_q, err_d;
  logic                  sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0] first_q, first_d;

  handshake_stall_gen #(
    .STALL_PERIOD(STALL_PERIOD)
  ) u_stall (
    .clk       (clk),
    .rst       (rst),
    .ready_mask(ins_ready)
  );

  assign xfer     = ins_valid & ins_ready;
  assign mismatch = (ins != EXPECTED);

  // A clear coinciding with a transfer restarts statistics with that token.
  always_comb begin
    tok_d    = tok_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    first_d  = first_q;
    if (clear) begin
      tok_d    = xfer ? CNT_WIDTH'(1) : '0;
      err_d    = '0;
      sticky_d = 1'b0;
      first_d  = '0;
      if (xfer && mismatch) begin
        err_d    = CNT_WIDTH'(1);
        sticky_d = 1'b1;
        first_d  = ins;
      end
    end else if (xfer) begin
      tok_d = CNT_WIDTH'(sat_inc(64'(tok_q), CNT_WIDTH));
      if (mismatch) begin
        err_d    = CNT_WIDTH'(sat_inc(64'(err_q), CNT_WIDTH));
        sticky_d = 1'b1;
        if (!sticky_q) first_d = ins;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_q    <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
      first_q  <= '0;
    end else begin
      tok_q    <= tok_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      first_q  <= first_d;
    end
  end

  assign tok_count      = tok_q;
  assign err_count      = err_q;
  assign err_sticky     = sticky_q;
  assign first_err_data = first_q;

`ifdef HANDSHAKE_SINK_PROTO_CHECK_EN
  logic                  pending_q, proto_q, proto_d, stalled;
  logic [DATA_WIDTH-1:0] hold_q;

  assign stalled = ins_valid & ~ins_ready;

  // After a stalled offer, valid must stay high with unchanged data.
  always_comb begin
    proto_d = proto_q;
    if (pending_q && (!ins_valid || (ins != hold_q))) proto_d = 1'b1;
    if (clear) proto_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      hold_q    <= '0;
      proto_q   <= 1'b0;
    end else begin
      pending_q <= stalled;
      if (stalled) hold_q <= ins;
      proto_q   <= proto_d;
    end
  end

  assign proto_err = proto_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_sink_const_check.sv
// Self-checking bench: two sink instances (no stall / stall period 4 with 4-bit counters)
// share one randomized stream and are compared every cycle against a behavioural model.
module tb_handshake_sink_const_check;

`ifdef HANDSHAKE_SINK_PROTO_CHECK_EN
  localparam bit PROTO_ON = 1'b1;
`else
  localparam bit PROTO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        insValid = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] insData = '0;

  logic        ready0, sticky0, proto0;
  logic [15:0] tok0, err0;
  logic [31:0] first0;
  logic        ready1, sticky1, proto1;
  logic [3:0]  tok1, err1;
  logic [15:0] first1;

  int checks = 0;
  int failures = 0;
  int k;

  int unsigned mTok[2];
  int unsigned mErr[2];
  bit          mSticky[2];
  bit          mProto[2];
  bit          mPend[2];
  logic [31:0] mFirst[2];
  logic [31:0] mHold[2];

  always #5 clk = ~clk;

  handshake_sink_const_check #(
    .DATA_WIDTH(32), .CNT_WIDTH(16), .STALL_PERIOD(0)
  ) dut0 (
    .clk(clk), .rst(rst), .ins(insData), .ins_valid(insValid), .ins_ready(ready0),
    .clear(clear), .tok_count(tok0), .err_count(err0), .err_sticky(sticky0),
    .first_err_data(first0), .proto_err(proto0)
  );

  handshake_sink_const_check #(
    .DATA_WIDTH(16), .EXPECTED(16'hCE7), .CNT_WIDTH(4), .STALL_PERIOD(4)
  ) dut1 (
    .clk(clk), .rst(rst), .ins(insData[15:0]), .ins_valid(insValid), .ins_ready(ready1),
    .clear(clear), .tok_count(tok1), .err_count(err1), .err_sticky(sticky1),
    .first_err_data(first1), .proto_err(proto1)
  );

  // Cycle index since reset release: cycle 0 is the one before the first edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  function automatic int perOf(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic int unsigned maxOf(input int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  function automatic logic [31:0] maskOf(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic bit modelReady(input int i);
    int p;
    p = perOf(i);
    if (!rst || k < 1) return 1'b0;
    return (p == 0) || ((k % p) != (p - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInst(input int i, input logic r, input logic [63:0] tok,
                           input logic [63:0] err, input logic st,
                           input logic [63:0] fe, input logic pe);
    checkOutput($sformatf("dut%0d.ins_ready", i), 64'(r), 64'(modelReady(i)));
    checkOutput($sformatf("dut%0d.tok_count", i), tok, rst ? 64'(mTok[i]) : 64'd0);
    checkOutput($sformatf("dut%0d.err_count", i), err, rst ? 64'(mErr[i]) : 64'd0);
    checkOutput($sformatf("dut%0d.err_sticky", i), 64'(st), rst ? 64'(mSticky[i]) : 64'd0);
    checkOutput($sformatf("dut%0d.first_err_data", i), fe, rst ? 64'(mFirst[i]) : 64'd0);
    checkOutput($sformatf("dut%0d.proto_err", i), 64'(pe), rst ? 64'(mProto[i]) : 64'd0);
  endtask

  // Advance the model by the coming clock edge using the inputs of the current cycle.
  task automatic modelStep(input int i);
    logic [31:0] d;
    bit rdy, x, bad;
    d   = insData & maskOf(i);
    rdy = modelReady(i);
    x   = insValid && rdy;
    bad = (d != 32'hCE7);
    if (!rst) begin
      mTok[i] = 0; mErr[i] = 0; mSticky[i] = 0; mFirst[i] = '0;
      mProto[i] = 0; mPend[i] = 0; mHold[i] = '0;
      return;
    end
    if (PROTO_ON) begin
      if (mPend[i] && (!insValid || d != mHold[i])) mProto[i] = 1'b1;
      if (clear) mProto[i] = 1'b0;
      mPend[i] = insValid && !rdy;
      if (mPend[i]) mHold[i] = d;
    end
    if (clear) begin
      mTok[i] = x ? 1 : 0;
      mErr[i] = (x && bad) ? 1 : 0;
      mSticky[i] = x && bad;
      mFirst[i] = (x && bad) ? d : 32'd0;
    end else if (x) begin
      if (mTok[i] < maxOf(i)) mTok[i] = mTok[i] + 1;
      if (bad) begin
        if (mErr[i] < maxOf(i)) mErr[i] = mErr[i] + 1;
        if (!mSticky[i]) mFirst[i] = d;
        mSticky[i] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    checkInst(0, ready0, 64'(tok0), 64'(err0), sticky0, 64'(first0), proto0);
    checkInst(1, ready1, 64'(tok1), 64'(err1), sticky1, 64'(first1), proto1);
    modelStep(0);
    modelStep(1);
  end

  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit c);
    @(posedge clk);
    #1;
    insValid = v;
    insData  = d;
    clear    = c;
  endtask

  task automatic idleWait();
    applyStimulus(1'b0, 32'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic releaseFromReset();
    @(posedge clk); #1; rst = 1'b0; insValid = 1'b0; clear = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
  endtask

  // Offers d on the next cycle in which the period-4 instance stalls.
  task automatic driveOnStallCycle(input logic [31:0] d);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      insValid = 1'b0;
      clear    = 1'b0;
      if (k % 4 == 3) begin
        insValid = 1'b1;
        insData  = d;
        break;
      end
    end
  endtask

  initial begin
    logic [16:0] lowMask;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready0", 64'(ready0), 64'd0);
    checkOutput("reset_ready1", 64'(ready1), 64'd0);
    checkOutput("reset_tok0", 64'(tok0), 64'd0);
    checkOutput("reset_first0", 64'(first0), 64'd0);

    @(posedge clk); #1 rst = 1'b1;
    repeat (10) applyStimulus(1'b1, 32'hCE7, 1'b0);
    idleWait();
    checkOutput("ten_tok0", 64'(tok0), 64'd10);
    checkOutput("ten_err0", 64'(err0), 64'd0);
    checkOutput("ten_sticky0", 64'(sticky0), 64'd0);
    checkOutput("ten_ready0", 64'(ready0), 64'd1);
    checkOutput("ten_tok1", 64'(tok1), 64'd8);

    releaseFromReset();
    @(negedge clk);
    lowMask[0] = !ready1;
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(1'b1, 32'hCE7, 1'b0);
      @(negedge clk);
      lowMask[c] = !ready1;
    end
    idleWait();
    checkOutput("stall_pattern1", 64'(lowMask), 64'h8889);
    checkOutput("stall_tok1", 64'(tok1), 64'd12);
    checkOutput("stall_tok0", 64'(tok0), 64'd16);

    applyStimulus(1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 32'hCE7, 1'b0);
    applyStimulus(1'b1, 32'h001, 1'b0);
    applyStimulus(1'b1, 32'hCE7, 1'b0);
    applyStimulus(1'b1, 32'h0FF, 1'b0);
    idleWait();
    checkOutput("mix_tok0", 64'(tok0), 64'd4);
    checkOutput("mix_err0", 64'(err0), 64'd2);
    checkOutput("mix_sticky0", 64'(sticky0), 64'd1);
    checkOutput("mix_first0", 64'(first0), 64'h001);

    applyStimulus(1'b1, 32'h123, 1'b1);
    idleWait();
    checkOutput("clrx_tok0", 64'(tok0), 64'd1);
    checkOutput("clrx_err0", 64'(err0), 64'd1);
    checkOutput("clrx_sticky0", 64'(sticky0), 64'd1);
    checkOutput("clrx_first0", 64'(first0), 64'h123);

    repeat (24) applyStimulus(1'b1, 32'h555, 1'b0);
    idleWait();
    checkOutput("sat_tok1", 64'(tok1), 64'd15);
    checkOutput("sat_err1", 64'(err1), 64'd15);
    repeat (4) applyStimulus(1'b1, 32'h555, 1'b0);
    idleWait();
    checkOutput("sat_hold_tok1", 64'(tok1), 64'd15);
    checkOutput("sat_hold_err1", 64'(err1), 64'd15);
    checkOutput("sat_err0", 64'(err0), 64'd29);

    applyStimulus(1'b0, 32'd0, 1'b1);
    driveOnStallCycle(32'hCE7);
    applyStimulus(1'b0, 32'd0, 1'b0);
    idleWait();
    checkOutput("proto_drop1", 64'(proto1), 64'(PROTO_ON));
    checkOutput("proto_drop0", 64'(proto0), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    idleWait();
    checkOutput("proto_clear1", 64'(proto1), 64'd0);
    driveOnStallCycle(32'hCE7);
    applyStimulus(1'b1, 32'h0AA, 1'b0);
    idleWait();
    checkOutput("proto_change1", 64'(proto1), 64'(PROTO_ON));
    applyStimulus(1'b0, 32'd0, 1'b1);
    idleWait();
    checkOutput("proto_clear2", 64'(proto1), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        @(posedge clk); #1;
        rst = 1'b0;
        insValid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        rst = 1'b1;
      end else begin
        case ($urandom_range(0, 3))
          0:       d = $urandom;
          1:       d = 32'hCE7 | (32'd1 << $urandom_range(16, 31));
          default: d = 32'hCE7;
        endcase
        applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 49) == 0);
      end
    end
    idleWait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
